// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: arbiter state, requester ids
// and the width of the fetch anti-starvation counter.
package mem_arb_pkg;

  localparam int ARB_WAIT_W = 4;

  typedef enum logic {
    RUN    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LD   = 2'd1,
    REQ_DAT  = 2'd2,
    REQ_FET  = 2'd3
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester handshakes, the shared read return and the
// main memory drive. The arbiter uses the slave view; the core, loader and
// memory side together use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);

  // UART program loader
  logic                  ld_lock;
  logic                  ld_req;
  logic                  ld_we;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic                  ld_gnt;
  logic                  ld_rvalid;

  // core data access
  logic                  dat_req;
  logic                  dat_we;
  logic [ADDR_WIDTH-1:0] dat_addr;
  logic [DATA_WIDTH-1:0] dat_wdata;
  logic                  dat_gnt;
  logic                  dat_rvalid;

  // core instruction fetch
  logic                  fet_req;
  logic [ADDR_WIDTH-1:0] fet_addr;
  logic                  fet_gnt;
  logic                  fet_rvalid;

  // shared read return and memory drive
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  locked;

  modport slave (
    input  ld_lock, ld_req, ld_we, ld_addr, ld_wdata,
    input  dat_req, dat_we, dat_addr, dat_wdata,
    input  fet_req, fet_addr,
    input  mem_rdata,
    output ld_gnt, ld_rvalid, dat_gnt, dat_rvalid, fet_gnt, fet_rvalid,
    output rdata, mem_addr, mem_we, mem_wdata, locked
  );

  modport master (
    output ld_lock, ld_req, ld_we, ld_addr, ld_wdata,
    output dat_req, dat_we, dat_addr, dat_wdata,
    output fet_req, fet_addr,
    output mem_rdata,
    input  ld_gnt, ld_rvalid, dat_gnt, dat_rvalid, fet_gnt, fet_rvalid,
    input  rdata, mem_addr, mem_we, mem_wdata, locked
  );

endinterface

// File: rtl/mem_port_arbiter_age.sv
// Saturating wait counter: counts cycles a requester is kept waiting and
// flags when it has waited MAX cycles so it can be promoted.
module arb_age_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  input  logic freeze,
  output logic sat
);

  localparam logic [ARB_WAIT_W-1:0] MAX_C = ARB_WAIT_W'(MAX);

  logic [ARB_WAIT_W-1:0] count;

  // freeze holds the value outright; otherwise clear wins over increment
  always_ff @(posedge clk) begin
    if (reset_n) begin
      count <= '0;
    end else if (!freeze) begin
      if (clr) begin
        count <= '0;
      end else if (inc && (count != MAX_C)) begin
        count <= count + ARB_WAIT_W'(1);
      end
    end
  end

  assign sat = (count == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port main memory shared by the UART loader, core
// data access and core instruction fetch. One access per cycle, grant is a
// combinational pulse, read data returns one cycle after the grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_t            state;
  req_id_t               winner;
  req_id_t               pend_id_p1;
  logic                  fet_sat;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // pick this cycle's owner; reset and LOCKED gate out everyone but the loader
  always_comb begin
    winner = REQ_NONE;
    if (!reset_n) begin
      if (bus.ld_req) begin
        winner = REQ_LD;
      end else if (state == RUN) begin
        if (bus.fet_req && fet_sat) begin
          winner = REQ_FET;
        end else if (bus.dat_req) begin
          winner = REQ_DAT;
        end else if (bus.fet_req) begin
          winner = REQ_FET;
        end
      end
    end
  end

  assign bus.ld_gnt  = (winner == REQ_LD);
  assign bus.dat_gnt = (winner == REQ_DAT);
  assign bus.fet_gnt = (winner == REQ_FET);

  // route the winner's fields to memory; idle cycles drive all zeros
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    case (winner)
      REQ_LD: begin
        win_we    = bus.ld_we;
        win_addr  = bus.ld_addr;
        win_wdata = bus.ld_wdata;
      end
      REQ_DAT: begin
        win_we    = bus.dat_we;
        win_addr  = bus.dat_addr;
        win_wdata = bus.dat_wdata;
      end
      REQ_FET: begin
        win_addr  = bus.fet_addr;
      end
      default: begin
        win_we    = 1'b0;
      end
    endcase
  end

  assign bus.mem_we    = win_we;
  assign bus.mem_addr  = win_addr;
  assign bus.mem_wdata = win_wdata;

  // fetch ages while denied so continuous data traffic cannot starve it
  arb_age_counter #(
    .MAX (MAX_WAIT)
  ) u_fet_age (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (bus.fet_req & ~bus.fet_gnt),
    .clr     (~bus.fet_req | bus.fet_gnt),
    .freeze  (state == LOCKED),
    .sat     (fet_sat)
  );

  // loader lock follows ld_lock one edge later
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= RUN;
    end else begin
      state <= bus.ld_lock ? LOCKED : RUN;
    end
  end

  // ---- stage p0 -> p1: remember who owns the read returning next cycle ----
  always_ff @(posedge clk) begin
    if (reset_n) begin
      pend_id_p1 <= REQ_NONE;
    end else begin
      pend_id_p1 <= (winner != REQ_NONE && !win_we) ? winner : REQ_NONE;
    end
  end

  assign bus.ld_rvalid  = (pend_id_p1 == REQ_LD);
  assign bus.dat_rvalid = (pend_id_p1 == REQ_DAT);
  assign bus.fet_rvalid = (pend_id_p1 == REQ_FET);
  assign bus.rdata      = bus.mem_rdata;
  assign bus.locked     = (state == LOCKED);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory (COUNT 255 × 12-bit, synchronous read, 1-cycle latency) between three requesters:
  - UART program loader
  - core data access (MOV_A_R / MOV_R_A)
  - core instruction fetch
- Sits between the core/loader and the main memory instance, clocked by the CPU clock.
- Per-cycle grant: fixed priority plus fetch anti-starvation aging.
- Exclusive loader lock for program download.

Parameters:
- ADDR_WIDTH, 12, memory address width
- DATA_WIDTH, 12, memory word width
- MAX_WAIT, 4, cycles fetch may be denied before it outranks data (1..15)

Ports:
- clk  in  1  CPU clock
- reset_n  in  1  synchronous reset, active-high (asserted = 1 resets)
- ld_lock  in  1  loader requests exclusive ownership
- ld_req  in  1  loader access request
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  ADDR_WIDTH  loader address
- ld_wdata  in  DATA_WIDTH  loader write data
- ld_gnt  out  1  loader granted this cycle
- ld_rvalid  out  1  loader read data valid on rdata
- dat_req  in  1  core data request
- dat_we  in  1  core data write / read
- dat_addr  in  ADDR_WIDTH  core data address
- dat_wdata  in  DATA_WIDTH  core data write data
- dat_gnt  out  1  core data granted
- dat_rvalid  out  1  core data read valid
- fet_req  in  1  fetch request (read only)
- fet_addr  in  ADDR_WIDTH  fetch address (program counter)
- fet_gnt  out  1  fetch granted
- fet_rvalid  out  1  fetch read valid
- rdata  out  DATA_WIDTH  shared read data (= mem_rdata)
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_we  out  1  to memory write_enable
- mem_wdata  out  DATA_WIDTH  to memory data_in
- mem_rdata  in  DATA_WIDTH  from memory data_out
- locked  out  1  arbiter in LOCKED state

Behaviour:
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt = 1.
  - gnt is a combinational 1-cycle pulse, at most one gnt per cycle.
  - The requester may drop req or present the next request in the cycle after gnt.
- Memory drive:
  - mem_addr, mem_we and mem_wdata are combinational muxes of the winner's fields.
  - No winner: mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - mem_we = winner_we & gnt. Fetch never writes.
- Read return:
  - Granted read at edge N → matching *_rvalid = 1 for the cycle after edge N.
  - rdata = mem_rdata passthrough.
  - rvalid flops hold the pending owner id; a granted write gives no rvalid.
- Throughput: one access per cycle, back-to-back grants allowed (even same requester).
- States:
  - RUN: priority ld > fet (if fet_wait == MAX_WAIT) > dat > fet.
  - LOCKED: only ld may be granted; dat_gnt = fet_gnt = 0.
  - RUN→LOCKED on the edge where ld_lock = 1. The cycle in which ld_lock first rises is still arbitrated as RUN.
  - LOCKED→RUN on the edge where ld_lock = 0.
  - An rvalid pending from a RUN-cycle grant is still delivered after entering LOCKED.
- fet_wait (4-bit):
  - +1 on each edge with fet_req & ~fet_gnt, saturating at MAX_WAIT.
  - Cleared on fet_gnt or fet_req = 0.
  - Frozen in LOCKED.
- Reset (reset_n = 1 at edge):
  - state = RUN, fet_wait = 0, all rvalid = 0, pending owner = none.
  - While reset_n = 1, all gnt = 0 and mem_we = 0 (combinationally gated).
  - A read granted the cycle before reset yields no rvalid.
- Address range checking is not done here; addresses pass through.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_t {RUN, LOCKED}
  - req_id_t {REQ_NONE, REQ_LD, REQ_DAT, REQ_FET}
  - constant ARB_WAIT_W = 4
- One sub-module, arb_age_counter: saturating wait counter with inc, clr and freeze inputs and a sat output, instantiated for fetch.
- Grant mux and rvalid pipeline stay in the top module.

Test Plan:
- Only fet_req, fet_addr = 0x005, mem holds 0x3A1 at 5 → fet_gnt same cycle; next cycle fet_rvalid = 1, rdata = 0x3A1.
- dat_req write (addr 0x010, wdata 0x0FF) with fet_req in the same cycle, MAX_WAIT = 4:
  - dat_gnt, mem_we = 1, mem_addr = 0x010 first.
  - fet granted next cycle; no dat_rvalid.
- dat_req held high continuously with fet_req → fet denied 4 cycles, then fet_gnt on cycle 5 despite dat_req; fet_wait returns to 0.
- ld_lock = 1 with dat_req and fet_req high → LOCKED from next cycle:
  - only ld writes to 0x000..0x003 granted; dat/fet gnt stay 0.
  - After ld_lock drops, dat granted first.
- Read grant to fet, then reset_n = 1 on the next edge → fet_rvalid stays 0, all gnt = 0 during reset, locked = 0 afterwards.
- ld, dat and fet all requesting in RUN with fet_wait = 0 → ld_gnt only; then dat; then fet (3 consecutive cycles, rvalids one cycle behind each read).
